// File: rtl/sd_host_pkg.sv
// Shared encodings for the SD host CMD-line sequencer: FSM states,
// response-type codes and error-status bit positions.
package sd_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_TX,
    ST_WAIT_RSP,
    ST_CHECK,
    ST_COMPLETE
  } cmd_state_t;

  localparam logic [1:0] RSP_NONE    = 2'b00;
  localparam logic [1:0] RSP_136     = 2'b01;
  localparam logic [1:0] RSP_48      = 2'b10;
  localparam logic [1:0] RSP_48_BUSY = 2'b11;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_CRC     = 1;
  localparam int ERR_END     = 2;
  localparam int ERR_INDEX   = 3;

  // R2 (136-bit) responses carry a reserved index field, so they are never index-checked.
  function automatic logic is_long_rsp(input logic [1:0] rsp_type);
    return (rsp_type == RSP_136);
  endfunction

endpackage

// File: rtl/sd_cmd_timeout.sv
// Counts SD-clock ticks while a response is awaited and flags when the
// NCR limit has been reached; the count holds at the limit.
module sd_cmd_timeout #(
  parameter int TIMEOUT_TICKS = 64,
  parameter int TCNT_W        = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TCNT_W-1:0] LIMIT = TCNT_W'(TIMEOUT_TICKS);

  logic [TCNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TCNT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Issues one SD command at a time to the CMD-line PHY, validates the
// response and maintains inhibit, completion, error and response registers.
module sd_cmd_sequencer
  import sd_host_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 64,
  parameter int TCNT_W        = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         sd_tick,
  input  logic         cmd_write,
  input  logic [15:0]  cmd_reg,
  input  logic [31:0]  arg_reg,
  input  logic         soft_rst_cmd,
  input  logic [3:0]   err_clr,
  output logic         phy_start,
  output logic [5:0]   phy_index,
  output logic [31:0]  phy_arg,
  input  logic         phy_tx_done,
  input  logic         phy_rsp_done,
  input  logic [5:0]   phy_rsp_index,
  input  logic         phy_rsp_crc_ok,
  input  logic         phy_rsp_end_ok,
  input  logic [127:0] phy_rsp_data,
  output logic         cmd_inhibit,
  output logic         cmd_complete,
  output logic [3:0]   err_status,
  output logic [127:0] response_out
);

  cmd_state_t   state;
  logic         idx_chk_en;
  logic         crc_chk_en;
  logic [1:0]   rsp_type;
  logic [5:0]   rsp_index;
  logic         rsp_crc_ok;
  logic         rsp_end_ok;
  logic [127:0] rsp_data;
  logic         expired;
  logic         tmr_clear;
  logic         tmr_enable;
  logic [3:0]   chk_err;
  logic [3:0]   err_set;
  logic         unused_cmd_bits;

  assign unused_cmd_bits = ^{cmd_reg[15:14], cmd_reg[7:5], cmd_reg[2]};

  assign tmr_clear  = (state != ST_WAIT_RSP) || soft_rst_cmd;
  assign tmr_enable = (state == ST_WAIT_RSP) && sd_tick;

  sd_cmd_timeout #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .TCNT_W        (TCNT_W)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (expired)
  );

  // Response checks run on the copy captured at phy_rsp_done.
  always_comb begin
    chk_err            = '0;
    chk_err[ERR_END]   = !rsp_end_ok;
    chk_err[ERR_CRC]   = crc_chk_en && !rsp_crc_ok;
    chk_err[ERR_INDEX] = idx_chk_en && !is_long_rsp(rsp_type) && (rsp_index != phy_index);
  end

  // A response arriving in the expiry cycle takes priority over the timeout.
  always_comb begin
    err_set = '0;
    if (!soft_rst_cmd) begin
      if (state == ST_WAIT_RSP && !phy_rsp_done && expired) begin
        err_set[ERR_TIMEOUT] = 1'b1;
      end
      if (state == ST_CHECK) begin
        err_set = chk_err;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      phy_start    <= 1'b0;
      phy_index    <= '0;
      phy_arg      <= '0;
      cmd_inhibit  <= 1'b0;
      cmd_complete <= 1'b0;
      err_status   <= '0;
      response_out <= '0;
      idx_chk_en   <= 1'b0;
      crc_chk_en   <= 1'b0;
      rsp_type     <= RSP_NONE;
      rsp_index    <= '0;
      rsp_crc_ok   <= 1'b0;
      rsp_end_ok   <= 1'b0;
      rsp_data     <= '0;
    end else begin
      err_status   <= (err_status & ~err_clr) | err_set;
      phy_start    <= 1'b0;
      cmd_complete <= 1'b0;
      if (soft_rst_cmd) begin
        state       <= ST_IDLE;
        cmd_inhibit <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cmd_write) begin
              phy_index   <= cmd_reg[13:8];
              phy_arg     <= arg_reg;
              idx_chk_en  <= cmd_reg[4];
              crc_chk_en  <= cmd_reg[3];
              rsp_type    <= cmd_reg[1:0];
              cmd_inhibit <= 1'b1;
              state       <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            phy_start <= 1'b1;
            state     <= ST_TX;
          end
          ST_TX: begin
            if (phy_tx_done) begin
              if (rsp_type == RSP_NONE) begin
                cmd_complete <= 1'b1;
                state        <= ST_COMPLETE;
              end else begin
                state <= ST_WAIT_RSP;
              end
            end
          end
          ST_WAIT_RSP: begin
            if (phy_rsp_done) begin
              rsp_index  <= phy_rsp_index;
              rsp_crc_ok <= phy_rsp_crc_ok;
              rsp_end_ok <= phy_rsp_end_ok;
              rsp_data   <= phy_rsp_data;
              state      <= ST_CHECK;
            end else if (expired) begin
              cmd_inhibit <= 1'b0;
              state       <= ST_IDLE;
            end
          end
          ST_CHECK: begin
            if (|chk_err) begin
              cmd_inhibit <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              if (is_long_rsp(rsp_type)) begin
                response_out <= {8'h00, rsp_data[127:8]};
              end else begin
                response_out <= {96'h0, rsp_data[31:0]};
              end
              cmd_complete <= 1'b1;
              state        <= ST_COMPLETE;
            end
          end
          ST_COMPLETE: begin
            cmd_inhibit <= 1'b0;
            state       <= ST_IDLE;
          end
          default: begin
            cmd_inhibit <= 1'b0;
            state       <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed testbench for sd_cmd_sequencer: command flows, response checks,
// timeout boundary, error W1C, soft reset and asynchronous reset.
module tb_sd_cmd_sequencer;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         sd_tick = 1'b0;
  logic         cmd_write = 1'b0;
  logic [15:0]  cmd_reg = '0;
  logic [31:0]  arg_reg = '0;
  logic         soft_rst_cmd = 1'b0;
  logic [3:0]   err_clr = '0;
  logic         phy_start;
  logic [5:0]   phy_index;
  logic [31:0]  phy_arg;
  logic         phy_tx_done = 1'b0;
  logic         phy_rsp_done = 1'b0;
  logic [5:0]   phy_rsp_index = '0;
  logic         phy_rsp_crc_ok = 1'b0;
  logic         phy_rsp_end_ok = 1'b0;
  logic [127:0] phy_rsp_data = '0;
  logic         cmd_inhibit;
  logic         cmd_complete;
  logic [3:0]   err_status;
  logic [127:0] response_out;

  int checks = 0;
  int errors = 0;

  sd_cmd_sequencer #(.TIMEOUT_TICKS(64), .TCNT_W(7)) dut (
    .clock          (clock),
    .reset          (reset),
    .sd_tick        (sd_tick),
    .cmd_write      (cmd_write),
    .cmd_reg        (cmd_reg),
    .arg_reg        (arg_reg),
    .soft_rst_cmd   (soft_rst_cmd),
    .err_clr        (err_clr),
    .phy_start      (phy_start),
    .phy_index      (phy_index),
    .phy_arg        (phy_arg),
    .phy_tx_done    (phy_tx_done),
    .phy_rsp_done   (phy_rsp_done),
    .phy_rsp_index  (phy_rsp_index),
    .phy_rsp_crc_ok (phy_rsp_crc_ok),
    .phy_rsp_end_ok (phy_rsp_end_ok),
    .phy_rsp_data   (phy_rsp_data),
    .cmd_inhibit    (cmd_inhibit),
    .cmd_complete   (cmd_complete),
    .err_status     (err_status),
    .response_out   (response_out)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Write pulse, then two cycles; reports phy_start as seen at the expected latency.
  task automatic issue_cmd(input logic [15:0] cmd, input logic [31:0] arg, output logic started);
    cmd_reg   = cmd;
    arg_reg   = arg;
    cmd_write = 1'b1;
    step();
    cmd_write = 1'b0;
    step();
    started = phy_start;
  endtask

  task automatic send_tx_done();
    phy_tx_done = 1'b1;
    step();
    phy_tx_done = 1'b0;
  endtask

  task automatic send_rsp(input logic [5:0] idx, input logic crc_ok, input logic end_ok,
                          input logic [127:0] data);
    phy_rsp_index  = idx;
    phy_rsp_crc_ok = crc_ok;
    phy_rsp_end_ok = end_ok;
    phy_rsp_data   = data;
    phy_rsp_done   = 1'b1;
    step();
    phy_rsp_done   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if ({phy_start, cmd_inhibit, cmd_complete, err_status, phy_index, phy_arg} !== 44'h0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %h expected 0",
               {phy_start, cmd_inhibit, cmd_complete, err_status, phy_index, phy_arg});
    end
    checks++;
    if (response_out !== 128'h0) begin
      errors++;
      $display("[TB] FAIL reset_rsp: got %h expected 0", response_out);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_cmd0();
    cmd_reg   = 16'h0000;
    arg_reg   = 32'h0;
    cmd_write = 1'b1;
    step();
    cmd_write = 1'b0;
    checks++;
    if ({cmd_inhibit, phy_start} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL cmd0_issue: inhibit,start got %b expected 10", {cmd_inhibit, phy_start});
    end
    step();
    checks++;
    if (phy_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cmd0_start_latency: got %b expected 1", phy_start);
    end
    step();
    checks++;
    if (phy_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cmd0_start_pulse: got %b expected 0", phy_start);
    end
    send_rsp(6'd0, 1'b1, 1'b1, 128'h1234);
    checks++;
    if ({cmd_complete, cmd_inhibit} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL cmd0_stray_rsp: complete,inhibit got %b expected 01", {cmd_complete, cmd_inhibit});
    end
    send_tx_done();
    checks++;
    if ({cmd_complete, cmd_inhibit, err_status} !== 6'b110000) begin
      errors++;
      $display("[TB] FAIL cmd0_complete: got %b expected 110000", {cmd_complete, cmd_inhibit, err_status});
    end
    step();
    checks++;
    if ({cmd_complete, cmd_inhibit} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL cmd0_idle: complete,inhibit got %b expected 00", {cmd_complete, cmd_inhibit});
    end
  endtask

  task automatic test_cmd8();
    logic started;
    issue_cmd(16'h081A, 32'h0000_01AA, started);
    checks++;
    if ({started, phy_index, phy_arg} !== {1'b1, 6'd8, 32'h0000_01AA}) begin
      errors++;
      $display("[TB] FAIL cmd8_issue: got %b/%0d/%h expected 1/8/000001aa", started, phy_index, phy_arg);
    end
    send_tx_done();
    send_rsp(6'd8, 1'b1, 1'b1, {96'hDEAD_BEEF_0BAD_F00D_CAFE_BABE, 32'h0000_01AA});
    checks++;
    if (cmd_complete !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cmd8_check_cycle: complete got %b expected 0", cmd_complete);
    end
    step();
    checks++;
    if ({cmd_complete, err_status} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL cmd8_complete: got %b expected 10000", {cmd_complete, err_status});
    end
    checks++;
    if (response_out !== 128'h1AA) begin
      errors++;
      $display("[TB] FAIL cmd8_response: got %h expected 1aa", response_out);
    end
    step();
  endtask

  task automatic test_cmd2();
    logic started;
    issue_cmd(16'h0219, 32'h0, started);
    send_tx_done();
    send_rsp(6'd63, 1'b1, 1'b1, 128'hFEDCBA98_76543210_FEDCBA98_76543210);
    step();
    checks++;
    if ({cmd_complete, err_status} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL cmd2_complete: got %b expected 10000", {cmd_complete, err_status});
    end
    checks++;
    if (response_out !== 128'h00FEDCBA_98765432_10FEDCBA_98765432) begin
      errors++;
      $display("[TB] FAIL cmd2_response: got %h expected 00fedcba9876543210fedcba98765432", response_out);
    end
    step();
  endtask

  task automatic test_timeout();
    logic started;
    issue_cmd(16'h111A, 32'h0000_0200, started);
    send_tx_done();
    sd_tick = 1'b1;
    repeat (64) step();
    sd_tick = 1'b0;
    checks++;
    if ({err_status, cmd_inhibit} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL timeout_early: err,inhibit got %b expected 00001", {err_status, cmd_inhibit});
    end
    step();
    checks++;
    if ({err_status, cmd_inhibit, cmd_complete} !== 6'b000100) begin
      errors++;
      $display("[TB] FAIL timeout_fire: got %b expected 000100", {err_status, cmd_inhibit, cmd_complete});
    end
    err_clr = 4'b0001;
    step();
    err_clr = 4'b0000;
    checks++;
    if (err_status !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL timeout_clear: got %b expected 0000", err_status);
    end
  endtask

  task automatic test_rsp_wins();
    logic started;
    issue_cmd(16'h081A, 32'h0000_01AA, started);
    send_tx_done();
    sd_tick = 1'b1;
    repeat (64) step();
    sd_tick = 1'b0;
    send_rsp(6'd8, 1'b1, 1'b1, 128'h120);
    checks++;
    if (err_status !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL rsp_wins_err: got %b expected 0000", err_status);
    end
    step();
    checks++;
    if ({cmd_complete, response_out} !== {1'b1, 128'h120}) begin
      errors++;
      $display("[TB] FAIL rsp_wins_complete: got %b/%h expected 1/120", cmd_complete, response_out);
    end
    step();
  endtask

  task automatic test_errors();
    logic started;
    issue_cmd(16'h081A, 32'h0000_01AA, started);
    send_tx_done();
    send_rsp(6'd9, 1'b0, 1'b1, 128'h5555);
    err_clr = 4'b1111;
    step();
    err_clr = 4'b0000;
    checks++;
    if ({err_status, cmd_inhibit, cmd_complete} !== 6'b101000) begin
      errors++;
      $display("[TB] FAIL err_idx_crc: got %b expected 101000", {err_status, cmd_inhibit, cmd_complete});
    end
    checks++;
    if (response_out !== 128'h120) begin
      errors++;
      $display("[TB] FAIL err_rsp_kept: got %h expected 120", response_out);
    end
    err_clr = 4'b0010;
    step();
    err_clr = 4'b0000;
    checks++;
    if (err_status !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL err_w1c: got %b expected 1000", err_status);
    end
    issue_cmd(16'h0002, 32'h0, started);
    send_tx_done();
    send_rsp(6'd5, 1'b0, 1'b0, 128'h7777);
    step();
    checks++;
    if ({err_status, cmd_complete, response_out} !== {4'b1100, 1'b0, 128'h120}) begin
      errors++;
      $display("[TB] FAIL err_end_only: got %b/%b/%h expected 1100/0/120", err_status, cmd_complete, response_out);
    end
  endtask

  task automatic test_soft_reset();
    logic started;
    issue_cmd(16'h081A, 32'h0000_01AA, started);
    send_tx_done();
    cmd_reg   = 16'h3700;
    arg_reg   = 32'hFFFF_FFFF;
    cmd_write = 1'b1;
    step();
    cmd_write = 1'b0;
    checks++;
    if ({phy_index, phy_arg, cmd_inhibit} !== {6'd8, 32'h0000_01AA, 1'b1}) begin
      errors++;
      $display("[TB] FAIL busy_write_ignored: got %0d/%h/%b expected 8/000001aa/1", phy_index, phy_arg, cmd_inhibit);
    end
    soft_rst_cmd = 1'b1;
    step();
    soft_rst_cmd = 1'b0;
    checks++;
    if ({cmd_inhibit, phy_start, err_status, response_out} !== {2'b00, 4'b1100, 128'h120}) begin
      errors++;
      $display("[TB] FAIL soft_rst: got %b%b/%b/%h expected 00/1100/120", cmd_inhibit, phy_start, err_status, response_out);
    end
    send_rsp(6'd8, 1'b1, 1'b1, 128'h999);
    step();
    checks++;
    if ({cmd_complete, cmd_inhibit, response_out} !== {2'b00, 128'h120}) begin
      errors++;
      $display("[TB] FAIL soft_rst_stray_rsp: got %b%b/%h expected 00/120", cmd_complete, cmd_inhibit, response_out);
    end
    cmd_reg      = 16'h0000;
    cmd_write    = 1'b1;
    soft_rst_cmd = 1'b1;
    step();
    cmd_write    = 1'b0;
    soft_rst_cmd = 1'b0;
    step();
    checks++;
    if ({cmd_inhibit, phy_start} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL soft_rst_beats_write: got %b expected 00", {cmd_inhibit, phy_start});
    end
  endtask

  task automatic test_async_reset();
    logic started;
    issue_cmd(16'h1100, 32'hCAFE_F00D, started);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({phy_start, cmd_inhibit, cmd_complete, err_status, phy_index, phy_arg} !== 44'h0) begin
      errors++;
      $display("[TB] FAIL async_reset_ctrl: got %h expected 0",
               {phy_start, cmd_inhibit, cmd_complete, err_status, phy_index, phy_arg});
    end
    checks++;
    if (response_out !== 128'h0) begin
      errors++;
      $display("[TB] FAIL async_reset_rsp: got %h expected 0", response_out);
    end
    step();
    reset = 1'b1;
    step();
    issue_cmd(16'h0000, 32'h0, started);
    checks++;
    if (started !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_issue: got %b expected 1", started);
    end
    send_tx_done();
    step();
  endtask

  initial begin
    $display("[TB] starting sd_cmd_sequencer tests");
    test_reset();
    test_cmd0();
    test_cmd8();
    test_cmd2();
    test_timeout();
    test_rsp_wins();
    test_errors();
    test_soft_reset();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
